tqv_reg_arbiter: RTL and testbench

- Two-requester arbiter and sequencer for the TinyQV-style peripheral register port (address, data_in, data_write_n, data_read_n, data_out, data_ready).
- Requester 0 is the SPI register bridge; requester 1 is an on-chip control source, for example a tone/note sequencer.
- Grants are round-robin, one transaction at a time.
- The block generates the one-cycle write strobe, holds read strobes until data_ready, and returns width-masked read data.

---
 rtl/tqv_reg_arbiter.sv | 197 +++++++++++++++++++
 tb/tb_tqv_reg_arbiter.sv | 221 ++++++++++++++++++++++
 2 files changed

// File: rtl/tqv_reg_arbiter.sv
// tqv_reg_arbiter: round-robin arbiter and sequencer between two requesters
// (SPI register bridge = 0, on-chip control source = 1) and a TinyQV-style
// peripheral register port. One transaction in flight at a time.
// Optional feature macro: TQV_ARB_TIMEOUT_EN. When defined, a read that never
// sees data_ready is aborted after READ_TIMEOUT cycles with rsp_err set.
module tqv_reg_arbiter #(
  parameter int ADDR_W       = 6,
  parameter int DATA_W       = 32,
  parameter int READ_TIMEOUT = 255
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              req0_valid,
  input  logic [ADDR_W-1:0] req0_addr,
  input  logic [DATA_W-1:0] req0_wdata,
  input  logic [1:0]        req0_write_n,
  input  logic [1:0]        req0_read_n,
  output logic              req0_done,
  input  logic              req1_valid,
  input  logic [ADDR_W-1:0] req1_addr,
  input  logic [DATA_W-1:0] req1_wdata,
  input  logic [1:0]        req1_write_n,
  input  logic [1:0]        req1_read_n,
  output logic              req1_done,
  output logic [DATA_W-1:0] rsp_rdata,
  output logic              rsp_err,
  output logic [ADDR_W-1:0] address,
  output logic [DATA_W-1:0] data_in,
  output logic [1:0]        data_write_n,
  output logic [1:0]        data_read_n,
  input  logic [DATA_W-1:0] data_out,
  input  logic              data_ready
);

  typedef enum logic [1:0] {IDLE, WRITE, READ, DONE} state_t;

  state_t              state_reg, state_next;
  logic                last_reg, last_next;     // requester granted most recently
  logic                sel_reg, sel_next;       // requester owning the current transaction
  logic [1:0]          rn_reg, rn_next;         // latched read width
  logic [ADDR_W-1:0]   address_reg, address_next;
  logic [DATA_W-1:0]   data_in_reg, data_in_next;
  logic [1:0]          write_n_reg, write_n_next;
  logic [1:0]          read_n_reg, read_n_next;
  logic [1:0]          done_reg, done_next;
  logic [DATA_W-1:0]   rdata_reg, rdata_next;
  logic                err_reg, err_next;

  logic                pick;
  logic [ADDR_W-1:0]   g_addr;
  logic [DATA_W-1:0]   g_wdata;
  logic [1:0]          g_wn, g_rn;

`ifdef TQV_ARB_TIMEOUT_EN
  logic [7:0]          cnt_reg, cnt_next;
`else
  logic                unused_timeout;
  assign unused_timeout = ^READ_TIMEOUT;
`endif

  // Keep the byte, half or word selected by the read width; other bits zero.
  function automatic logic [DATA_W-1:0] mask_rdata(input logic [1:0] w,
                                                   input logic [DATA_W-1:0] d);
    case (w)
      2'b00:   mask_rdata = {{(DATA_W-8){1'b0}}, d[7:0]};
      2'b01:   mask_rdata = {{(DATA_W-16){1'b0}}, d[15:0]};
      default: mask_rdata = d;
    endcase
  endfunction

  // Round-robin choice: a lone requester wins; on contention the one not granted last wins.
  always_comb begin
    pick    = req1_valid & (~req0_valid | ~last_reg);
    g_addr  = pick ? req1_addr    : req0_addr;
    g_wdata = pick ? req1_wdata   : req0_wdata;
    g_wn    = pick ? req1_write_n : req0_write_n;
    g_rn    = pick ? req1_read_n  : req0_read_n;
  end

  // Next-state and next-output logic; done and err are single-cycle by default.
  always_comb begin
    state_next   = state_reg;
    last_next    = last_reg;
    sel_next     = sel_reg;
    rn_next      = rn_reg;
    address_next = address_reg;
    data_in_next = data_in_reg;
    write_n_next = write_n_reg;
    read_n_next  = read_n_reg;
    done_next    = 2'b00;
    rdata_next   = rdata_reg;
    err_next     = 1'b0;
`ifdef TQV_ARB_TIMEOUT_EN
    cnt_next     = cnt_reg;
`endif
    case (state_reg)
      IDLE: begin
        if (req0_valid || req1_valid) begin
          last_next    = pick;
          sel_next     = pick;
          rn_next      = g_rn;
          address_next = g_addr;
          data_in_next = g_wdata;
          if (g_wn != 2'b11) begin
            write_n_next = g_wn;
            state_next   = WRITE;
          end else if (g_rn != 2'b11) begin
            read_n_next = g_rn;
            state_next  = READ;
`ifdef TQV_ARB_TIMEOUT_EN
            cnt_next    = 8'd0;
`endif
          end else begin
            rdata_next      = '0;
            done_next[pick] = 1'b1;
            state_next      = DONE;
          end
        end
      end
      WRITE: begin
        write_n_next       = 2'b11;
        done_next[sel_reg] = 1'b1;
        state_next         = DONE;
      end
      READ: begin
        if (data_ready) begin
          read_n_next        = 2'b11;
          rdata_next         = mask_rdata(rn_reg, data_out);
          done_next[sel_reg] = 1'b1;
          state_next         = DONE;
        end
`ifdef TQV_ARB_TIMEOUT_EN
        else if (cnt_reg == 8'(READ_TIMEOUT - 1)) begin
          read_n_next        = 2'b11;
          rdata_next         = '0;
          err_next           = 1'b1;
          done_next[sel_reg] = 1'b1;
          state_next         = DONE;
        end else begin
          cnt_next = cnt_reg + 8'd1;
        end
`endif
      end
      DONE: begin
        write_n_next = 2'b11;
        read_n_next  = 2'b11;
        state_next   = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  // State and output registers, cleared asynchronously.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg   <= IDLE;
      last_reg    <= 1'b1;
      sel_reg     <= 1'b0;
      rn_reg      <= 2'b11;
      address_reg <= '0;
      data_in_reg <= '0;
      write_n_reg <= 2'b11;
      read_n_reg  <= 2'b11;
      done_reg    <= 2'b00;
      rdata_reg   <= '0;
      err_reg     <= 1'b0;
`ifdef TQV_ARB_TIMEOUT_EN
      cnt_reg     <= 8'd0;
`endif
    end else begin
      state_reg   <= state_next;
      last_reg    <= last_next;
      sel_reg     <= sel_next;
      rn_reg      <= rn_next;
      address_reg <= address_next;
      data_in_reg <= data_in_next;
      write_n_reg <= write_n_next;
      read_n_reg  <= read_n_next;
      done_reg    <= done_next;
      rdata_reg   <= rdata_next;
      err_reg     <= err_next;
`ifdef TQV_ARB_TIMEOUT_EN
      cnt_reg     <= cnt_next;
`endif
    end
  end

  assign req0_done    = done_reg[0];
  assign req1_done    = done_reg[1];
  assign rsp_rdata    = rdata_reg;
  assign rsp_err      = err_reg;
  assign address      = address_reg;
  assign data_in      = data_in_reg;
  assign data_write_n = write_n_reg;
  assign data_read_n  = read_n_reg;

endmodule

// File: tb/tb_tqv_reg_arbiter.sv
// Directed bench for tqv_reg_arbiter: writes, reads, arbitration order,
// no-op and write-wins cases, async reset during a read, optional timeout.
module tb_tqv_reg_arbiter;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        req0_valid, req1_valid;
  logic [5:0]  req0_addr, req1_addr;
  logic [31:0] req0_wdata, req1_wdata;
  logic [1:0]  req0_write_n, req0_read_n, req1_write_n, req1_read_n;
  logic        req0_done, req1_done;
  logic [31:0] rsp_rdata;
  logic        rsp_err;
  logic [5:0]  address;
  logic [31:0] data_in;
  logic [1:0]  data_write_n, data_read_n;
  logic [31:0] data_out;
  logic        data_ready;

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  tqv_reg_arbiter dut (
    .clk(clk), .rst_n(rst_n),
    .req0_valid(req0_valid), .req0_addr(req0_addr), .req0_wdata(req0_wdata),
    .req0_write_n(req0_write_n), .req0_read_n(req0_read_n), .req0_done(req0_done),
    .req1_valid(req1_valid), .req1_addr(req1_addr), .req1_wdata(req1_wdata),
    .req1_write_n(req1_write_n), .req1_read_n(req1_read_n), .req1_done(req1_done),
    .rsp_rdata(rsp_rdata), .rsp_err(rsp_err),
    .address(address), .data_in(data_in),
    .data_write_n(data_write_n), .data_read_n(data_read_n),
    .data_out(data_out), .data_ready(data_ready)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(negedge clk);
  endtask

  initial begin
    int order [4];
    int got;
    int n;
    order = '{0, 1, 0, 1};

    rst_n = 1'b0;
    req0_valid = 1'b0; req0_addr = '0; req0_wdata = '0; req0_write_n = 2'b11; req0_read_n = 2'b11;
    req1_valid = 1'b0; req1_addr = '0; req1_wdata = '0; req1_write_n = 2'b11; req1_read_n = 2'b11;
    data_out = '0; data_ready = 1'b0;
    tick(); tick();
    chk("rst_write_n", 32'(data_write_n), 32'd3);
    chk("rst_read_n", 32'(data_read_n), 32'd3);
    chk("rst_address", 32'(address), 32'd0);
    chk("rst_data_in", data_in, 32'd0);
    chk("rst_done", {30'd0, req1_done, req0_done}, 32'd0);
    chk("rst_rdata", rsp_rdata, 32'd0);
    chk("rst_err", 32'(rsp_err), 32'd0);
    rst_n = 1'b1;
    tick();
    $display("step reset released");

    // req0 word write
    req0_valid = 1'b1; req0_addr = 6'h04; req0_wdata = 32'h12345678; req0_write_n = 2'b10; req0_read_n = 2'b11;
    tick();
    chk("wr_strobe", 32'(data_write_n), 32'd2);
    chk("wr_address", 32'(address), 32'h04);
    chk("wr_data_in", data_in, 32'h12345678);
    chk("wr_no_done_yet", 32'(req0_done), 32'd0);
    req0_valid = 1'b0; req0_wdata = 32'hFFFFFFFF;
    tick();
    chk("wr_strobe_one_cycle", 32'(data_write_n), 32'd3);
    chk("wr_done", 32'(req0_done), 32'd1);
    chk("wr_address_stable", 32'(address), 32'h04);
    chk("wr_data_stable", data_in, 32'h12345678);
    tick();
    chk("wr_done_pulse", 32'(req0_done), 32'd0);
    $display("step req0 write done");

    // req1 byte read, data_ready after 3 READ cycles
    req1_valid = 1'b1; req1_addr = 6'h08; req1_write_n = 2'b11; req1_read_n = 2'b00;
    tick();
    chk("rd_strobe_1", 32'(data_read_n), 32'd0);
    chk("rd_address", 32'(address), 32'h08);
    tick();
    chk("rd_strobe_2", 32'(data_read_n), 32'd0);
    tick();
    chk("rd_strobe_3", 32'(data_read_n), 32'd0);
    chk("rd_not_done", 32'(req1_done), 32'd0);
    data_ready = 1'b1; data_out = 32'hAABBCCDD;
    tick();
    chk("rd_done", 32'(req1_done), 32'd1);
    chk("rd_other_done", 32'(req0_done), 32'd0);
    chk("rd_rdata", rsp_rdata, 32'h000000DD);
    chk("rd_strobe_off", 32'(data_read_n), 32'd3);
    chk("rd_err", 32'(rsp_err), 32'd0);
    req1_valid = 1'b0; data_out = 32'h11111111;
    tick(); tick();
    chk("rd_ready_ignored_idle", rsp_rdata, 32'h000000DD);
    data_ready = 1'b0;
    $display("step req1 read done");

    // contention: both valid continuously, writes to distinct addresses
    req0_valid = 1'b1; req0_addr = 6'h01; req0_write_n = 2'b10; req0_read_n = 2'b11;
    req1_valid = 1'b1; req1_addr = 6'h02; req1_write_n = 2'b10; req1_read_n = 2'b11;
    for (int t = 0; t < 4; t++) begin
      got = -1;
      n = 0;
      while (got < 0 && n < 12) begin
        tick();
        n++;
        chk("rr_single_done", 32'(req0_done & req1_done), 32'd0);
        if (req0_done) got = 0;
        else if (req1_done) got = 1;
      end
      if (got < 0) begin
        chk("rr_timeout", 32'd1, 32'd0);
      end else begin
        chk("rr_grant_order", 32'(got), 32'(order[t]));
        chk("rr_address", 32'(address), (got == 0) ? 32'h01 : 32'h02);
        $display("step rr transaction %0d granted req%0d", t, got);
      end
    end
    req0_valid = 1'b0; req1_valid = 1'b0;
    tick();

    // write and read widths both set: write wins
    req0_valid = 1'b1; req0_addr = 6'h03; req0_wdata = 32'hCAFEF00D; req0_write_n = 2'b01; req0_read_n = 2'b01;
    tick();
    chk("ww_write_strobe", 32'(data_write_n), 32'd1);
    chk("ww_no_read", 32'(data_read_n), 32'd3);
    req0_valid = 1'b0;
    tick();
    chk("ww_done", 32'(req0_done), 32'd1);
    chk("ww_no_read_2", 32'(data_read_n), 32'd3);
    chk("ww_rdata_kept", rsp_rdata, 32'h000000DD);
    tick();
    $display("step write-wins done");

    // no-op from req1
    req1_valid = 1'b1; req1_addr = 6'h07; req1_write_n = 2'b11; req1_read_n = 2'b11;
    tick();
    chk("nop_done", 32'(req1_done), 32'd1);
    chk("nop_rdata", rsp_rdata, 32'd0);
    chk("nop_strobes", {28'd0, data_write_n, data_read_n}, 32'hF);
    req1_valid = 1'b0;
    tick();
    chk("nop_done_pulse", 32'(req1_done), 32'd0);
    $display("step no-op done");

    // half read with data_ready already high
    req1_valid = 1'b1; req1_addr = 6'h0A; req1_read_n = 2'b01;
    data_ready = 1'b1; data_out = 32'h89ABCDEF;
    tick();
    chk("half_strobe", 32'(data_read_n), 32'd1);
    chk("half_not_done", 32'(req1_done), 32'd0);
    chk("half_rdata_held", rsp_rdata, 32'd0);
    req1_valid = 1'b0;
    tick();
    chk("half_done", 32'(req1_done), 32'd1);
    chk("half_rdata", rsp_rdata, 32'h0000CDEF);
    data_ready = 1'b0;
    tick();
    $display("step half read done");

    // async reset during READ
    req0_valid = 1'b1; req0_addr = 6'h05; req0_write_n = 2'b11; req0_read_n = 2'b01;
    tick();
    chk("ar_strobe", 32'(data_read_n), 32'd1);
    req0_valid = 1'b0;
    #2 rst_n = 1'b0;
    #1;
    chk("ar_read_n_async", 32'(data_read_n), 32'd3);
    chk("ar_address_async", 32'(address), 32'd0);
    chk("ar_rdata_async", rsp_rdata, 32'd0);
    tick();
    req0_valid = 1'b1; req0_addr = 6'h09; req0_write_n = 2'b10;
    req1_valid = 1'b1; req1_addr = 6'h0A; req1_write_n = 2'b10;
    rst_n = 1'b1;
    tick();
    chk("ar_first_grant_addr", 32'(address), 32'h09);
    chk("ar_first_strobe", 32'(data_write_n), 32'd2);
    req0_valid = 1'b0; req1_valid = 1'b0;
    tick();
    chk("ar_done0", 32'(req0_done), 32'd1);
    chk("ar_done1", 32'(req1_done), 32'd0);
    tick();
    $display("step async reset done");

`ifdef TQV_ARB_TIMEOUT_EN
    req1_valid = 1'b1; req1_addr = 6'h0B; req1_write_n = 2'b11; req1_read_n = 2'b10;
    tick();
    req1_valid = 1'b0;
    n = 0;
    while (!req1_done && n < 300) begin
      if (data_read_n == 2'b10) n++;
      tick();
    end
    chk("to_read_cycles", 32'(n), 32'd255);
    chk("to_done", 32'(req1_done), 32'd1);
    chk("to_err", 32'(rsp_err), 32'd1);
    chk("to_rdata", rsp_rdata, 32'd0);
    chk("to_read_n", 32'(data_read_n), 32'd3);
    tick();
    chk("to_err_pulse", 32'(rsp_err), 32'd0);
    $display("step timeout done");
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
